regfile_cmd_master: RTL and testbench

- Command-level initiator that drives the register-file port (A1/A2/A3/WD3/WE3 out, RD1/RD2 in) from the controller side, i.e. the other end of the register-file DUT port.
- Accepts READ/WRITE/COPY/SWAP commands on a valid/ready channel, sequences them into register-file port cycles, and returns results on a valid/ready response channel.
- Sits between a test or control sequencer and an 8x8 register file: synchronous write on posedge when WE3=1, combinational read.

---
 rtl/regfile_cmd_master.sv | 198 +++++++++++++++++++
 tb/tb_regfile_cmd_master.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_cmd_master.sv
// Command-level initiator for an 8x8 register-file port: turns READ/WRITE/COPY/SWAP
// commands into A1/A2/A3/WD3/WE3 cycles and returns results on a valid/ready channel.
module regfile_cmd_master #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_a,
  input  logic [ADDR_W-1:0] cmd_b,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_op,
  output logic [DATA_W-1:0] rsp_data1,
  output logic [DATA_W-1:0] rsp_data2,
  output logic [ADDR_W-1:0] A1,
  output logic [ADDR_W-1:0] A2,
  output logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] WD3,
  output logic              WE3,
  input  logic [DATA_W-1:0] RD1,
  input  logic [DATA_W-1:0] RD2,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_COPY  = 2'b10;
  localparam logic [1:0] OP_SWAP  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    SWAP_A,
    WRITE,
    RESP
  } state_t;

  state_t              state, state_n;
  logic [1:0]          op_q, op_n;
  logic [ADDR_W-1:0]   a_q, a_n;
  logic [ADDR_W-1:0]   b_q, b_n;
  logic [ADDR_W-1:0]   dst_q, dst_n;
  logic [ADDR_W-1:0]   a1_n, a2_n, a3_n;
  logic [DATA_W-1:0]   wd3_n;
  logic                we3_n;
  logic                rsp_valid_n;
  logic [1:0]          rsp_op_n;
  logic [DATA_W-1:0]   rsp_data1_n, rsp_data2_n;
  logic [CNT_W-1:0]    op_count_n;

  assign cmd_ready = (state == IDLE) && reset;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      dst_q     <= '0;
      A1        <= '0;
      A2        <= '0;
      A3        <= '0;
      WD3       <= '0;
      WE3       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_op    <= '0;
      rsp_data1 <= '0;
      rsp_data2 <= '0;
      op_count  <= '0;
    end else begin
      state     <= state_n;
      op_q      <= op_n;
      a_q       <= a_n;
      b_q       <= b_n;
      dst_q     <= dst_n;
      A1        <= a1_n;
      A2        <= a2_n;
      A3        <= a3_n;
      WD3       <= wd3_n;
      WE3       <= we3_n;
      rsp_valid <= rsp_valid_n;
      rsp_op    <= rsp_op_n;
      rsp_data1 <= rsp_data1_n;
      rsp_data2 <= rsp_data2_n;
      op_count  <= op_count_n;
    end
  end

  // rsp_data1 doubles as the holding register for old R[a] between the two SWAP writes.
  always_comb begin
    state_n     = state;
    op_n        = op_q;
    a_n         = a_q;
    b_n         = b_q;
    dst_n       = dst_q;
    a1_n        = A1;
    a2_n        = A2;
    a3_n        = A3;
    wd3_n       = WD3;
    we3_n       = WE3;
    rsp_valid_n = rsp_valid;
    rsp_op_n    = rsp_op;
    rsp_data1_n = rsp_data1;
    rsp_data2_n = rsp_data2;
    op_count_n  = op_count;

    unique case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_n  = cmd_op;
          a_n   = cmd_a;
          b_n   = cmd_b;
          dst_n = cmd_dst;
          if (cmd_op == OP_WRITE) begin
            a3_n        = cmd_dst;
            wd3_n       = cmd_wdata;
            we3_n       = 1'b1;
            rsp_data1_n = cmd_wdata;
            rsp_data2_n = '0;
            state_n     = WRITE;
          end else begin
            a1_n    = cmd_a;
            a2_n    = cmd_b;
            we3_n   = 1'b0;
            state_n = READ;
          end
        end
      end

      READ: begin
        rsp_data1_n = RD1;
        rsp_data2_n = RD2;
        unique case (op_q)
          OP_COPY: begin
            a3_n    = dst_q;
            wd3_n   = RD1;
            we3_n   = 1'b1;
            state_n = WRITE;
          end
          OP_SWAP: begin
            a3_n    = a_q;
            wd3_n   = RD2;
            we3_n   = 1'b1;
            state_n = SWAP_A;
          end
          default: begin
            rsp_valid_n = 1'b1;
            rsp_op_n    = op_q;
            state_n     = RESP;
          end
        endcase
      end

      SWAP_A: begin
        a3_n    = b_q;
        wd3_n   = rsp_data1;
        we3_n   = 1'b1;
        state_n = WRITE;
      end

      WRITE: begin
        we3_n       = 1'b0;
        rsp_valid_n = 1'b1;
        rsp_op_n    = op_q;
        state_n     = RESP;
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          op_count_n  = op_count + CNT_W'(1);
          state_n     = IDLE;
        end
      end

      default: begin
        we3_n   = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  we3_only_in_write: assert property (@(posedge clk) disable iff (!reset)
    WE3 |-> (state == WRITE || state == SWAP_A));

  rsp_held_while_stalled: assert property (@(posedge clk) disable iff (!reset)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_data1) && $stable(rsp_data2) && $stable(rsp_op)));

endmodule

// File: tb/tb_regfile_cmd_master.sv
// Self-checking bench for regfile_cmd_master: directed table, reset-mid-SWAP sequence,
// then randomized commands against a command-level register-file model.
module tb_regfile_cmd_master;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_COPY  = 2'b10;
  localparam logic [1:0] OP_SWAP  = 2'b11;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid, cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_a, cmd_b, cmd_dst;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid, rsp_ready;
  logic [1:0]        rsp_op;
  logic [DATA_W-1:0] rsp_data1, rsp_data2;
  logic [ADDR_W-1:0] A1, A2, A3;
  logic [DATA_W-1:0] WD3;
  logic              WE3;
  logic [DATA_W-1:0] RD1, RD2;
  logic              busy;
  logic [CNT_W-1:0]  op_count;

  int checks = 0;
  int errors = 0;
  int completed = 0;

  logic [DATA_W-1:0] rf [8];
  logic [DATA_W-1:0] model [8];
  logic clear_rf;

  regfile_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_dst(cmd_dst), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
    .rsp_data1(rsp_data1), .rsp_data2(rsp_data2),
    .A1(A1), .A2(A2), .A3(A3), .WD3(WD3), .WE3(WE3), .RD1(RD1), .RD2(RD2),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // The register file on the other end of the port: synchronous write, combinational read.
  always @(posedge clk) begin
    if (clear_rf) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else if (WE3) begin
      rf[A3] <= WD3;
    end
  end
  assign RD1 = rf[A1];
  assign RD2 = rf[A2];

  typedef struct {
    logic [1:0] op;
    logic [2:0] a, b, dst;
    logic [7:0] wd, e1, e2;
  } vec_t;

  vec_t vecs [14];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Command-level semantics: results, latency, write-pulse count and the final write.
  task automatic model_cmd(input logic [1:0] op, input logic [2:0] a, b, dst, input logic [7:0] wd,
                           output logic [7:0] e1, e2, output int elat, ewe,
                           output logic [2:0] ewa, output logic [7:0] ewd);
    ewa = dst;
    ewd = wd;
    case (op)
      OP_READ:  begin e1 = model[a]; e2 = model[b]; elat = 1; ewe = 0; end
      OP_WRITE: begin e1 = wd; e2 = 8'h00; elat = 1; ewe = 1; model[dst] = wd; end
      OP_COPY:  begin e1 = model[a]; e2 = model[b]; elat = 2; ewe = 1;
                      ewd = model[a]; model[dst] = model[a]; end
      default:  begin e1 = model[a]; e2 = model[b]; elat = 3; ewe = 2;
                      ewa = b; ewd = e1; model[a] = e2; model[b] = e1; end
    endcase
  endtask

  // Drives one command from the idle phase (#1 after an edge) through its response handshake.
  task automatic apply_stimulus(input logic [1:0] op, input logic [2:0] a, b, dst, input logic [7:0] wd,
                                input int stall, input logic [7:0] e1, e2,
                                output logic [7:0] d1, d2, output logic [1:0] rop,
                                output int lat, we_cnt, output logic [2:0] gwa, output logic [7:0] gwd,
                                output logic timed_out);
    int guard = 0;
    timed_out = 1'b0;
    lat = 0;
    we_cnt = 0;
    gwa = '0;
    gwd = '0;
    while (!cmd_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!cmd_ready) begin
      timed_out = 1'b1;
      return;
    end
    cmd_valid = 1'b1;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_dst = dst; cmd_wdata = wd;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_a = 3'($urandom); cmd_b = 3'($urandom);
    cmd_dst = 3'($urandom); cmd_wdata = 8'($urandom);
    if (WE3) begin we_cnt++; gwa = A3; gwd = WD3; end
    while (!rsp_valid) begin
      if (lat >= 20) begin
        timed_out = 1'b1;
        return;
      end
      @(posedge clk); #1;
      lat++;
      if (WE3) begin we_cnt++; gwa = A3; gwd = WD3; end
    end
    d1 = rsp_data1;
    d2 = rsp_data2;
    rop = rsp_op;
    for (int s = 0; s < stall; s++) begin
      cmd_valid = 1'b1;
      cmd_op = OP_WRITE; cmd_dst = 3'($urandom); cmd_wdata = 8'($urandom);
      @(posedge clk); #1;
      check_output("stall_rsp_valid", rsp_valid, 1);
      check_output("stall_data1", rsp_data1, e1);
      check_output("stall_data2", rsp_data2, e2);
      check_output("stall_cmd_ready", cmd_ready, 0);
      check_output("stall_we3", WE3, 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [2:0] a, b, dst, input logic [7:0] wd,
                         input int stall, input logic use_tab, input logic [7:0] t1, t2);
    logic [7:0] e1, e2, d1, d2, ewd, gwd;
    logic [2:0] ewa, gwa;
    logic [1:0] rop;
    int elat, ewe, lat, wec;
    logic to;
    model_cmd(op, a, b, dst, wd, e1, e2, elat, ewe, ewa, ewd);
    if (use_tab) begin
      e1 = t1;
      e2 = t2;
    end
    apply_stimulus(op, a, b, dst, wd, stall, e1, e2, d1, d2, rop, lat, wec, gwa, gwd, to);
    if (to) begin
      check_output("rsp_timeout", 1, 0);
      return;
    end
    completed++;
    check_output("rsp_data1", d1, e1);
    check_output("rsp_data2", d2, e2);
    check_output("rsp_op", rop, op);
    check_output("latency", lat, elat);
    check_output("we3_cycles", wec, ewe);
    if (ewe > 0) begin
      check_output("last_write_addr", gwa, ewa);
      check_output("last_write_data", gwd, ewd);
    end
    check_output("op_count", op_count, completed[CNT_W-1:0]);
    check_output("cmd_ready_after", cmd_ready, 1);
    check_output("busy_after", busy, 0);
  endtask

  initial begin
    vecs[0]  = '{OP_WRITE, 3'd0, 3'd0, 3'd3, 8'hA5, 8'hA5, 8'h00};
    vecs[1]  = '{OP_READ,  3'd3, 3'd3, 3'd0, 8'h00, 8'hA5, 8'hA5};
    vecs[2]  = '{OP_WRITE, 3'd0, 3'd0, 3'd1, 8'h11, 8'h11, 8'h00};
    vecs[3]  = '{OP_WRITE, 3'd0, 3'd0, 3'd2, 8'h22, 8'h22, 8'h00};
    vecs[4]  = '{OP_SWAP,  3'd1, 3'd2, 3'd0, 8'h00, 8'h11, 8'h22};
    vecs[5]  = '{OP_READ,  3'd1, 3'd2, 3'd0, 8'h00, 8'h22, 8'h11};
    vecs[6]  = '{OP_WRITE, 3'd0, 3'd0, 3'd4, 8'h5C, 8'h5C, 8'h00};
    vecs[7]  = '{OP_COPY,  3'd4, 3'd4, 3'd6, 8'h00, 8'h5C, 8'h5C};
    vecs[8]  = '{OP_READ,  3'd6, 3'd4, 3'd0, 8'h00, 8'h5C, 8'h5C};
    vecs[9]  = '{OP_WRITE, 3'd0, 3'd0, 3'd5, 8'h77, 8'h77, 8'h00};
    vecs[10] = '{OP_SWAP,  3'd5, 3'd5, 3'd0, 8'h00, 8'h77, 8'h77};
    vecs[11] = '{OP_READ,  3'd5, 3'd3, 3'd0, 8'h00, 8'h77, 8'hA5};
    vecs[12] = '{OP_COPY,  3'd6, 3'd3, 3'd6, 8'h00, 8'h5C, 8'hA5};
    vecs[13] = '{OP_READ,  3'd6, 3'd0, 3'd0, 8'h00, 8'h5C, 8'h00};

    for (int i = 0; i < 8; i++) model[i] = '0;
    reset = 1'b0;
    clear_rf = 1'b1;
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_dst = '0; cmd_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_cmd_ready", cmd_ready, 0);
    check_output("reset_rsp_valid", rsp_valid, 0);
    check_output("reset_we3", WE3, 0);
    check_output("reset_addrs", {A1, A2, A3, WD3}, 0);
    check_output("reset_rsp", {rsp_op, rsp_data1, rsp_data2}, 0);
    check_output("reset_op_count", op_count, 0);
    check_output("reset_busy", busy, 0);
    reset = 1'b1;
    clear_rf = 1'b0;
    @(posedge clk); #1;
    check_output("idle_cmd_ready", cmd_ready, 1);

    // Directed table; vector 1 also holds the response for 10 cycles.
    for (int i = 0; i < 14; i++)
      run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dst, vecs[i].wd,
              (i == 1) ? 10 : 0, 1'b1, vecs[i].e1, vecs[i].e2);

    // Reset during a SWAP after the first write has landed.
    run_cmd(OP_WRITE, 3'd0, 3'd0, 3'd1, 8'hAA, 0, 1'b0, 8'h00, 8'h00);
    run_cmd(OP_WRITE, 3'd0, 3'd0, 3'd2, 8'hBB, 0, 1'b0, 8'h00, 8'h00);
    cmd_valid = 1'b1;
    cmd_op = OP_SWAP; cmd_a = 3'd1; cmd_b = 3'd2;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check_output("swap_first_we3", WE3, 1);
    check_output("swap_first_addr", A3, 1);
    @(posedge clk); #1;
    check_output("swap_second_addr", A3, 2);
    reset = 1'b0;
    #1;
    check_output("midswap_we3", WE3, 0);
    check_output("midswap_rsp_valid", rsp_valid, 0);
    check_output("midswap_op_count", op_count, 0);
    check_output("midswap_cmd_ready", cmd_ready, 0);
    @(posedge clk); #1;
    check_output("midswap_r1", rf[1], 8'hBB);
    check_output("midswap_r2", rf[2], 8'hBB);
    reset = 1'b1;
    model[1] = 8'hBB;
    completed = 0;
    @(posedge clk); #1;
    check_output("post_reset_busy", busy, 0);
    check_output("post_reset_rsp_valid", rsp_valid, 0);
    run_cmd(OP_READ, 3'd1, 3'd2, 3'd0, 8'h00, 0, 1'b1, 8'hBB, 8'hBB);

    // Random traffic long enough to wrap op_count.
    for (int n = 0; n < 300; n++)
      run_cmd(2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom),
              int'($urandom_range(0, 2)), 1'b0, 8'h00, 8'h00);

    for (int i = 0; i < 8; i++)
      check_output("final_regfile", rf[i], model[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
